mips_wb_capture: RTL and testbench

- Consumer end of the write-back → register_file path: observes every WB-stage register write (reg_write_en, reg_write_dest, reg_write_data).
- Buffers each write into a timestamped FIFO that the bench drains with a valid/ready handshake.
- Keeps a shadow 8x16 register file with two read ports. The bench compares these against the DUT's reg_read_data_1/2.
- Sits in the bench alongside the DUT interface; it is synthesizable and never drives DUT signals.

---
 rtl/mips_wb_capture.sv | 135 +++++++++++++
 tb/tb_mips_wb_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_wb_capture.sv
// Write-back observer: timestamps every WB register write into a FWFT FIFO
// drained with valid/ready, and mirrors the writes into a shadow register file.
module mips_wb_capture #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int DATA_W  = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  logic [2:0]        reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic              cap_ready,
  input  logic              flush,
  input  logic              clear_err,
  input  logic [2:0]        shadow_addr_1,
  input  logic [2:0]        shadow_addr_2,
  output logic              cap_valid,
  output logic [2:0]        cap_dest,
  output logic [DATA_W-1:0] cap_data,
  output logic [15:0]       cap_cycle,
  output logic [PTR_W:0]    fifo_count,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic [DATA_W-1:0] shadow_data_1,
  output logic [DATA_W-1:0] shadow_data_2
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  // Handshake: an entry leaves the FIFO on a rising edge where cap_valid and
  // cap_ready are both 1; cap_* hold steady while cap_valid=1 and cap_ready=0.

  logic [2:0]        mem_dest_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q  [DEPTH];
  logic [15:0]       mem_cycle_q [DEPTH];
  logic [DATA_W-1:0] shadow_q    [8];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [15:0]      cycle_q;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic empty, full, pop, push_ok, drop, shadow_we;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  // Flush discards any push or pop in its edge and never counts as a drop.
  assign pop     = !empty && cap_ready && !flush;
  assign push_ok = reg_write_en && !flush && (!full || cap_ready);
  assign drop    = reg_write_en && !flush && full && !cap_ready;

  assign shadow_we = reg_write_en && !(R0_ZERO && (reg_write_dest == 3'd0));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + (PTR_W+1)'(1);
      else if (!push_ok && pop) count_d = count_q - (PTR_W+1)'(1);
    end
    // A drop in the same edge as clear_err leaves a fresh error behind.
    if (clear_err) begin
      overflow_d   = drop;
      drop_count_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cycle_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cycle_q      <= cycle_q + 16'd1;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_dest_q[i]  <= '0;
        mem_data_q[i]  <= '0;
        mem_cycle_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_dest_q[wr_ptr_q]  <= reg_write_dest;
      mem_data_q[wr_ptr_q]  <= reg_write_data;
      mem_cycle_q[wr_ptr_q] <= cycle_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[reg_write_dest] <= reg_write_data;
    end
  end

  assign cap_valid  = !empty;
  assign cap_dest   = empty ? '0 : mem_dest_q[rd_ptr_q];
  assign cap_data   = empty ? '0 : mem_data_q[rd_ptr_q];
  assign cap_cycle  = empty ? '0 : mem_cycle_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  assign shadow_data_1 = shadow_q[shadow_addr_1];
  assign shadow_data_2 = shadow_q[shadow_addr_2];

endmodule

// File: tb/tb_mips_wb_capture.sv
// Directed bench for mips_wb_capture: queue scoreboard for the capture FIFO,
// reference arrays for the shadow file, cycle stamp and error counters.
module tb_mips_wb_capture;

  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 16;
  localparam int W      = 35;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_write_en;
  logic [2:0]        reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              cap_ready, flush, clear_err;
  logic [2:0]        shadow_addr_1, shadow_addr_2;
  logic              cap_valid;
  logic [2:0]        cap_dest;
  logic [DATA_W-1:0] cap_data;
  logic [15:0]       cap_cycle;
  logic [PTR_W:0]    fifo_count;
  logic              overflow;
  logic [7:0]        drop_count;
  logic [DATA_W-1:0] shadow_data_1, shadow_data_2;

  mips_wb_capture #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .cap_ready(cap_ready), .flush(flush), .clear_err(clear_err),
    .shadow_addr_1(shadow_addr_1), .shadow_addr_2(shadow_addr_2),
    .cap_valid(cap_valid), .cap_dest(cap_dest), .cap_data(cap_data), .cap_cycle(cap_cycle),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
    .shadow_data_1(shadow_data_1), .shadow_data_2(shadow_data_2)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] sh_m[8];
  logic [15:0]       cyc_m;
  logic              ov_m;
  logic [7:0]        dc_m;
  logic [W-1:0]      head;
  logic [2:0]        td;
  logic [15:0]       tv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) sh_m[i] = '0;
    cyc_m = '0;
    ov_m  = 1'b0;
    dc_m  = '0;
  endtask

  // One clock: drive, check pre-edge outputs, advance the model, check post-edge.
  task automatic cycle(input logic en, input logic [2:0] dest, input logic [15:0] data,
                       input logic rdy, input logic fl, input logic clr);
    logic [2:0] a1;
    logic       drop;
    a1   = 3'($urandom_range(0, 7));
    drop = 1'b0;
    reg_write_en   = en;
    reg_write_dest = dest;
    reg_write_data = data;
    cap_ready      = rdy;
    flush          = fl;
    clear_err      = clr;
    shadow_addr_1  = a1;
    shadow_addr_2  = dest;
    #1;
    check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    check("cap_valid", 64'(cap_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("cap_dest", 64'(cap_dest), 64'(head[34:32]));
      check("cap_data", 64'(cap_data), 64'(head[31:16]));
      check("cap_cycle", 64'(cap_cycle), 64'(head[15:0]));
    end
    check("shadow_data_1", 64'(shadow_data_1), 64'(sh_m[a1]));
    check("shadow_data_2", 64'(shadow_data_2), 64'(sh_m[dest]));
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (en) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({dest, data, cyc_m});
        else drop = 1'b1;
      end
    end
    if (clr) begin
      ov_m = drop;
      dc_m = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ov_m = 1'b1;
      if (dc_m != 8'hFF) dc_m = dc_m + 8'd1;
    end
    if (en && dest != 3'd0) sh_m[dest] = data;
    cyc_m = cyc_m + 16'd1;
    @(posedge clk);
    #1;
    check("overflow", 64'(overflow), 64'(ov_m));
    check("drop_count", 64'(drop_count), 64'(dc_m));
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 3'd0, 16'h0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    reg_write_en = 1'b0; reg_write_dest = '0; reg_write_data = '0;
    cap_ready = 1'b0; flush = 1'b0; clear_err = 1'b0;
    shadow_addr_1 = '0; shadow_addr_2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Mid-stream reset with 3 entries queued
    cycle(1'b1, 3'd1, 16'h1111, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 16'h3333, 1'b0, 1'b0, 1'b0);
    check("pre_reset_count", 64'(fifo_count), 64'd3);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_cap_valid", 64'(cap_valid), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_cap_dest", 64'(cap_dest), 64'd0);
    check("rst_cap_data", 64'(cap_data), 64'd0);
    check("rst_cap_cycle", 64'(cap_cycle), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      shadow_addr_1 = 3'(i);
      shadow_addr_2 = 3'(i + 4);
      #1;
      check("rst_shadow_1", 64'(shadow_data_1), 64'd0);
      check("rst_shadow_2", 64'(shadow_data_2), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    // First edge after release is cycle 0; write r3 at cycle 5
    repeat (5) idle(1'b0);
    cycle(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    shadow_addr_1 = 3'd3;
    #1;
    check("beef_valid", 64'(cap_valid), 64'd1);
    check("beef_dest", 64'(cap_dest), 64'd3);
    check("beef_data", 64'(cap_data), 64'hBEEF);
    check("beef_cycle", 64'(cap_cycle), 64'd5);
    check("beef_shadow", 64'(shadow_data_1), 64'hBEEF);
    idle(1'b1);

    // Ordering under backpressure, then in-order drain
    for (int i = 1; i <= 5; i++) cycle(1'b1, 3'(i), 16'(i * 16'h11), 1'b0, 1'b0, 1'b0);
    check("order_count", 64'(fifo_count), 64'd5);
    check("order_head", 64'(cap_data), 64'h0011);
    repeat (5) idle(1'b1);
    check("order_drained", 64'(cap_valid), 64'd0);

    // Ten writes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) cycle(1'b1, 3'((i % 7) + 1), 16'(16'hA000 + i), 1'b0, 1'b0, 1'b0);
    check("full_count", 64'(fifo_count), 64'd8);
    check("full_overflow", 64'(overflow), 64'd1);
    check("full_drops", 64'(drop_count), 64'd2);
    shadow_addr_1 = 3'd2;
    shadow_addr_2 = 3'd3;
    #1;
    check("dropped_in_shadow_9", 64'(shadow_data_1), 64'hA008);
    check("dropped_in_shadow_10", 64'(shadow_data_2), 64'hA009);
    cycle(1'b1, 3'd4, 16'hB000, 1'b1, 1'b0, 1'b0);
    check("full_push_pop_drops", 64'(drop_count), 64'd2);
    check("full_push_pop_count", 64'(fifo_count), 64'd8);
    cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("clear_overflow", 64'(overflow), 64'd0);
    cycle(1'b1, 3'd5, 16'hB001, 1'b0, 1'b0, 1'b1);
    check("clear_vs_drop_ovf", 64'(overflow), 64'd1);
    check("clear_vs_drop_cnt", 64'(drop_count), 64'd1);
    cycle(1'b1, 3'd6, 16'hC0DE, 1'b1, 1'b1, 1'b0);
    shadow_addr_1 = 3'd6;
    #1;
    check("flush_count", 64'(fifo_count), 64'd0);
    check("flush_shadow", 64'(shadow_data_1), 64'hC0DE);
    check("flush_keeps_overflow", 64'(overflow), 64'd1);

    // drop_count saturation
    for (int i = 0; i < DEPTH + 260; i++) cycle(1'b1, 3'd7, 16'(i), 1'b0, 1'b0, 1'b0);
    check("drop_saturate", 64'(drop_count), 64'd255);
    cycle(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("sat_cleared", 64'(drop_count), 64'd0);

    // r0 captured in FIFO but never in the shadow file
    cycle(1'b1, 3'd0, 16'h1234, 1'b0, 1'b0, 1'b0);
    shadow_addr_1 = 3'd0;
    #1;
    check("r0_dest", 64'(cap_dest), 64'd0);
    check("r0_data", 64'(cap_data), 64'h1234);
    check("r0_shadow", 64'(shadow_data_1), 64'd0);
    idle(1'b1);

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      td = 3'($urandom_range(0, 7));
      tv = 16'($urandom_range(0, 16'hFFFF));
      cycle(1'($urandom_range(0, 1)), td, tv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 9) == 0));
    end
    repeat (DEPTH) idle(1'b1);

    // Cycle stamp wrap
    while (cyc_m != 16'hFFFF) idle(1'b1);
    cycle(1'b1, 3'd5, 16'h5555, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd6, 16'h6666, 1'b0, 1'b0, 1'b0);
    check("wrap_stamp_ffff", 64'(cap_cycle), 64'hFFFF);
    idle(1'b1);
    check("wrap_stamp_0000", 64'(cap_cycle), 64'h0000);
    repeat (2) idle(1'b1);

    // Fill and drain 20 times to wrap the pointers
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        td = 3'($urandom_range(0, 7));
        tv = 16'($urandom_range(0, 16'hFFFF));
        cycle(1'b1, td, tv, 1'b0, 1'b0, 1'b0);
      end
      check("fill_count", 64'(fifo_count), 64'(DEPTH));
      repeat (DEPTH) idle(1'b1);
    end
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
